// File: rtl/jet_frame_loader.sv
// Collects a feature frame from a valid/ready stream into a shadow buffer, then launches it
// to the inference network as one registered vector, with completion and timeout tracking.
module jet_frame_loader #(
  parameter int WIDTH      = 16,
  parameter int NFRAC      = 10,
  parameter int INPUT_SIZE = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    input_ready,
  output logic signed [WIDTH-1:0] input_data [INPUT_SIZE-1:0],
  input  logic                    output_ready,
  output logic                    frame_err,
  output logic                    timeout,
  output logic [15:0]             frames_sent
);

  localparam int IW = $clog2(INPUT_SIZE);
  localparam int CW = $clog2(TIMEOUT) + 1;

  // Fixed-point format is passed through untouched; only reject formats that cannot exist.
  if (INPUT_SIZE < 2 || NFRAC < 0 || NFRAC >= WIDTH) begin : g_param_check
    $error("jet_frame_loader: invalid parameter set");
  end

  typedef enum logic [1:0] {FILL, DROP, FULL} state_e;

  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic signed [WIDTH-1:0] shadow_q [INPUT_SIZE-1:0];
  logic                    busy_q;
  logic                    outPrev_q;
  logic [CW-1:0]           busyCnt_q;

  logic beatAccept;
  logic lastIdx;
  logic netRise;
  logic launchNow;

  assign s_ready    = (state_q != FULL);
  assign beatAccept = s_valid && s_ready;
  assign lastIdx    = (idx_q == IW'(INPUT_SIZE - 1));
  assign netRise    = output_ready && !outPrev_q;
  // Uses the registered busy flag, so a completion and a launch never share one edge.
  assign launchNow  = (state_q == FULL) && !busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      outPrev_q   <= 1'b0;
      busyCnt_q   <= '0;
      input_ready <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      frames_sent <= '0;
      for (int i = 0; i < INPUT_SIZE; i++) begin
        shadow_q[i]   <= '0;
        input_data[i] <= '0;
      end
    end else begin
      input_ready <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      outPrev_q   <= output_ready;

      case (state_q)
        FILL: begin
          if (beatAccept) begin
            shadow_q[idx_q] <= s_data;
            if (lastIdx) begin
              idx_q   <= '0;
              state_q <= s_last ? FULL : DROP;
            end else if (s_last) begin
              // Short frame: pad the unused tail with zeros before handing it on.
              for (int j = 0; j < INPUT_SIZE; j++) begin
                if (j > int'(idx_q)) shadow_q[j] <= '0;
              end
              frame_err <= 1'b1;
              idx_q     <= '0;
              state_q   <= FULL;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        DROP: begin
          if (beatAccept && s_last) begin
            frame_err <= 1'b1;
            state_q   <= FULL;
          end
        end
        FULL: begin
          if (launchNow) begin
            input_data  <= shadow_q;
            input_ready <= 1'b1;
            frames_sent <= frames_sent + 16'd1;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase

      // Network tracking: launch marks busy, a completion rise or the watchdog frees it.
      if (launchNow) begin
        busy_q    <= 1'b1;
        busyCnt_q <= '0;
      end else if (busy_q) begin
        if (netRise) begin
          busy_q    <= 1'b0;
          busyCnt_q <= '0;
        end else if (busyCnt_q == CW'(TIMEOUT - 1)) begin
          busy_q    <= 1'b0;
          busyCnt_q <= '0;
          timeout   <= 1'b1;
        end else begin
          busyCnt_q <= busyCnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jet_frame_loader.sv
// Randomized self-checking bench for jet_frame_loader: frames are built as beat queues and
// the expected vector, error pulse and launch timing are derived from the frame length.
module tb_jet_frame_loader;

  localparam int W = 16;
  localparam int N = 16;

  typedef logic signed [W-1:0] beat_q_t [$];
  typedef logic signed [W-1:0] vec_t [N-1:0];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          output_ready = 1'b0;
  logic signed [W-1:0] s_data = '0;

  logic          s_ready, input_ready, frame_err, timeout;
  logic [15:0]   frames_sent;
  vec_t          input_data;

  logic          tSReady, tInputReady, tFrameErr, tTimeout;
  logic [15:0]   tFramesSent;
  vec_t          tInputData;

  int testsRun = 0;
  int testsFailed = 0;

  jet_frame_loader #(.WIDTH(W), .NFRAC(10), .INPUT_SIZE(N), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .input_ready(input_ready), .input_data(input_data),
    .output_ready(output_ready), .frame_err(frame_err), .timeout(timeout),
    .frames_sent(frames_sent)
  );

  jet_frame_loader #(.WIDTH(W), .NFRAC(10), .INPUT_SIZE(N), .TIMEOUT(8)) dutShortTimeout (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(tSReady), .s_data(s_data),
    .s_last(s_last), .input_ready(tInputReady), .input_data(tInputData),
    .output_ready(output_ready), .frame_err(tFrameErr), .timeout(tTimeout),
    .frames_sent(tFramesSent)
  );

  always #5 clk = ~clk;

  // Edge counter plus pulse monitors sampled mid-cycle, recording how often and when.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int irCount = 0, irCyc = -1, feCount = 0, feCyc = -1;
  int tIrCount = 0, tIrCyc = -1, toCount = 0, toCyc = -1;
  always @(negedge clk) begin
    if (input_ready === 1'b1) begin irCount++; irCyc = cyc; end
    if (frame_err === 1'b1) begin feCount++; feCyc = cyc; end
    if (tInputReady === 1'b1) begin tIrCount++; tIrCyc = cyc; end
    if (tTimeout === 1'b1) begin toCount++; toCyc = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    output_ready = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  function automatic beat_q_t make_beats(input int n);
    beat_q_t b;
    for (int k = 0; k < n; k++) b.push_back(W'($urandom));
    return b;
  endfunction

  // Reference: the first N beats in order, anything missing reads as zero.
  function automatic vec_t expect_vec(input beat_q_t b);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = (i < b.size()) ? b[i] : '0;
    return v;
  endfunction

  function automatic int first_diff(input vec_t act, input vec_t exp);
    for (int i = 0; i < N; i++) if (act[i] !== exp[i]) return i;
    return -1;
  endfunction

  // Drives one beat per cycle; lastEdge is the edge that took the final beat.
  task automatic send_frame(input beat_q_t b, input bit withLast, output bit readyOk,
                            output int lastEdge);
    readyOk = 1'b1;
    for (int k = 0; k < b.size(); k++) begin
      s_valid = 1'b1;
      s_data  = b[k];
      s_last  = withLast && (k == b.size() - 1);
      if (s_ready !== 1'b1) readyOk = 1'b0;
      tick(1);
    end
    lastEdge = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = W'($urandom);
  endtask

  task automatic test_reset();
    vec_t zero;
    int d;
    for (int i = 0; i < N; i++) zero[i] = '0;
    do_reset();
    testsRun++; if (s_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
    testsRun++; if (input_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_input_ready: got %b expected 0", input_ready); end
    testsRun++; if (frame_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    testsRun++; if (timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    testsRun++; if (frames_sent !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_frames_sent: got %0d expected 0", frames_sent); end
    d = first_diff(input_data, zero);
    testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL reset_input_data: idx %0d got %0d expected 0", d, input_data[d]); end
  endtask

  task automatic test_normal();
    for (int it = 0; it < 2; it++) begin
      beat_q_t b;
      vec_t exp;
      bit rdy;
      int e, ir0, fe0, d;
      do_reset();
      if (it == 0) for (int k = 0; k < N; k++) b.push_back(W'(k * 64));
      else b = make_beats(N);
      exp = expect_vec(b);
      ir0 = irCount; fe0 = feCount;
      send_frame(b, 1'b1, rdy, e);
      tick(3);
      testsRun++; if (irCount - ir0 != 1 || irCyc != e + 1) begin testsFailed++; $display("[TB] FAIL normal_launch: got %0d pulses at edge %0d expected 1 at edge %0d", irCount - ir0, irCyc, e + 1); end
      d = first_diff(input_data, exp);
      testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL normal_data: idx %0d got %0d expected %0d", d, input_data[d], exp[d]); end
      testsRun++; if (frames_sent !== 16'd1) begin testsFailed++; $display("[TB] FAIL normal_frames_sent: got %0d expected 1", frames_sent); end
      testsRun++; if (feCount != fe0) begin testsFailed++; $display("[TB] FAIL normal_no_err: got %0d pulses expected 0", feCount - fe0); end
      testsRun++; if (!rdy) begin testsFailed++; $display("[TB] FAIL normal_ready: got stall expected s_ready=1 on every beat"); end
    end
  endtask

  task automatic test_short();
    for (int it = 0; it < 2; it++) begin
      beat_q_t b;
      vec_t exp;
      bit rdy;
      int e, ir0, fe0, d;
      do_reset();
      b = make_beats(it == 0 ? 5 : int'($urandom_range(1, N - 2)));
      exp = expect_vec(b);
      ir0 = irCount; fe0 = feCount;
      send_frame(b, 1'b1, rdy, e);
      tick(3);
      testsRun++; if (feCount - fe0 != 1 || feCyc != e) begin testsFailed++; $display("[TB] FAIL short_err (len %0d): got %0d pulses at edge %0d expected 1 at edge %0d", b.size(), feCount - fe0, feCyc, e); end
      testsRun++; if (irCount - ir0 != 1 || irCyc != e + 1) begin testsFailed++; $display("[TB] FAIL short_launch: got %0d pulses at edge %0d expected 1 at edge %0d", irCount - ir0, irCyc, e + 1); end
      d = first_diff(input_data, exp);
      testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL short_data (len %0d): idx %0d got %0d expected %0d", b.size(), d, input_data[d], exp[d]); end
      testsRun++; if (frames_sent !== 16'd1) begin testsFailed++; $display("[TB] FAIL short_frames_sent: got %0d expected 1", frames_sent); end
    end
  endtask

  task automatic test_long();
    for (int it = 0; it < 2; it++) begin
      beat_q_t b;
      vec_t exp;
      bit rdy;
      int e, ir0, fe0, d;
      do_reset();
      b = make_beats(it == 0 ? 20 : int'($urandom_range(N + 1, N + 8)));
      exp = expect_vec(b);
      ir0 = irCount; fe0 = feCount;
      send_frame(b, 1'b1, rdy, e);
      tick(3);
      testsRun++; if (!rdy) begin testsFailed++; $display("[TB] FAIL long_ready: got stall expected s_ready=1 throughout"); end
      testsRun++; if (feCount - fe0 != 1 || feCyc != e) begin testsFailed++; $display("[TB] FAIL long_err (len %0d): got %0d pulses at edge %0d expected 1 at edge %0d", b.size(), feCount - fe0, feCyc, e); end
      testsRun++; if (irCount - ir0 != 1 || irCyc != e + 1) begin testsFailed++; $display("[TB] FAIL long_launch: got %0d pulses at edge %0d expected 1 at edge %0d", irCount - ir0, irCyc, e + 1); end
      d = first_diff(input_data, exp);
      testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL long_data: idx %0d got %0d expected %0d", d, input_data[d], exp[d]); end
      testsRun++; if (frames_sent !== 16'd1) begin testsFailed++; $display("[TB] FAIL long_frames_sent: got %0d expected 1", frames_sent); end
    end
  endtask

  task automatic test_back_to_back();
    beat_q_t a, b;
    vec_t expA, expB;
    bit rdy;
    int eA, eB, r, ir0, d;
    do_reset();
    a = make_beats(N);
    b = make_beats(N);
    expA = expect_vec(a);
    expB = expect_vec(b);
    ir0 = irCount;
    send_frame(a, 1'b1, rdy, eA);
    tick(2);
    send_frame(b, 1'b1, rdy, eB);
    tick(4);
    testsRun++; if (s_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_buffered_ready: got %b expected 0", s_ready); end
    testsRun++; if (irCount - ir0 != 1) begin testsFailed++; $display("[TB] FAIL b2b_held: got %0d launches expected 1", irCount - ir0); end
    d = first_diff(input_data, expA);
    testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL b2b_data_held: idx %0d got %0d expected %0d", d, input_data[d], expA[d]); end
    output_ready = 1'b1;
    tick(1);
    r = cyc;
    tick(3);
    testsRun++; if (irCount - ir0 != 2 || irCyc != r + 1) begin testsFailed++; $display("[TB] FAIL b2b_launch: got %0d launches, last at edge %0d expected 2, last at edge %0d", irCount - ir0, irCyc, r + 1); end
    d = first_diff(input_data, expB);
    testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL b2b_data_second: idx %0d got %0d expected %0d", d, input_data[d], expB[d]); end
    testsRun++; if (frames_sent !== 16'd2) begin testsFailed++; $display("[TB] FAIL b2b_frames_sent: got %0d expected 2", frames_sent); end
    output_ready = 1'b0;
  endtask

  task automatic test_timeout();
    beat_q_t a, b;
    vec_t expB;
    bit rdy;
    int eA, eB, to0, tir0, d;
    do_reset();
    a = make_beats(N);
    b = make_beats(3);
    expB = expect_vec(b);
    to0 = toCount; tir0 = tIrCount;
    send_frame(a, 1'b1, rdy, eA);
    tick(1);
    send_frame(b, 1'b1, rdy, eB);
    tick(8);
    testsRun++; if (toCount - to0 != 1 || toCyc != eA + 9) begin testsFailed++; $display("[TB] FAIL timeout_pulse: got %0d pulses at edge %0d expected 1 at edge %0d", toCount - to0, toCyc, eA + 9); end
    testsRun++; if (tIrCount - tir0 != 2 || tIrCyc != eA + 10) begin testsFailed++; $display("[TB] FAIL timeout_relaunch: got %0d launches, last at edge %0d expected 2, last at edge %0d", tIrCount - tir0, tIrCyc, eA + 10); end
    d = first_diff(tInputData, expB);
    testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL timeout_data: idx %0d got %0d expected %0d", d, tInputData[d], expB[d]); end
    testsRun++; if (tFramesSent !== 16'd2) begin testsFailed++; $display("[TB] FAIL timeout_frames_sent: got %0d expected 2", tFramesSent); end
    testsRun++; if (frames_sent !== 16'd1 || s_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_long_watchdog: got sent %0d ready %b expected sent 1 ready 0", frames_sent, s_ready); end
  endtask

  task automatic test_reset_mid();
    beat_q_t part, b;
    vec_t exp;
    bit rdy;
    int e, ir0, fe0, d;
    do_reset();
    part = make_beats(7);
    b = make_beats(N);
    exp = expect_vec(b);
    ir0 = irCount; fe0 = feCount;
    send_frame(part, 1'b0, rdy, e);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    testsRun++; if (s_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_ready: got %b expected 1", s_ready); end
    tick(3);
    testsRun++; if (irCount != ir0 || feCount != fe0) begin testsFailed++; $display("[TB] FAIL midreset_quiet: got %0d launches %0d errors expected 0 and 0", irCount - ir0, feCount - fe0); end
    send_frame(b, 1'b1, rdy, e);
    tick(3);
    testsRun++; if (irCount - ir0 != 1 || irCyc != e + 1) begin testsFailed++; $display("[TB] FAIL midreset_launch: got %0d launches at edge %0d expected 1 at edge %0d", irCount - ir0, irCyc, e + 1); end
    d = first_diff(input_data, exp);
    testsRun++; if (d != -1) begin testsFailed++; $display("[TB] FAIL midreset_data: idx %0d got %0d expected %0d", d, input_data[d], exp[d]); end
    testsRun++; if (frames_sent !== 16'd1) begin testsFailed++; $display("[TB] FAIL midreset_frames_sent: got %0d expected 1", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short();
    test_long();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/jet_frame_loader.md
JET_FRAME_LOADER -- requirements
Module: jet_frame_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16: feature word width, signed fixed point.
REQ-002 SHALL have parameter NFRAC, default 10: fractional bits; carried through unchanged, no arithmetic.
REQ-003 SHALL have parameter INPUT_SIZE, default 16: features per frame (≥2).
REQ-004 SHALL have parameter TIMEOUT, default 4096: maximum cycles to wait for network completion.
REQ-005 SHALL have `clk`, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have `reset`, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have `s_valid`, input, 1 bit: upstream feature beat valid.
REQ-008 SHALL have `s_ready`, output, 1 bit: loader accepts the beat.
REQ-009 SHALL have `s_data`, input, signed [WIDTH-1:0]: feature word.
REQ-010 SHALL have `s_last`, input, 1 bit: final beat of the upstream frame.
REQ-011 SHALL have `input_ready`, output, 1 bit: launch pulse to the inference network.
REQ-012 SHALL have `input_data`, output, signed [WIDTH-1:0] array [INPUT_SIZE-1:0]: registered feature vector to the network.
REQ-013 SHALL have `output_ready`, input, 1 bit: completion from the network, level or pulse.
REQ-014 SHALL have `frame_err`, output, 1 bit: one-cycle pulse on a malformed frame.
REQ-015 SHALL have `timeout`, output, 1 bit: one-cycle pulse when network completion does not arrive.
REQ-016 SHALL have `frames_sent`, output, [15:0]: count of launches; wraps at 2^16.

Function
REQ-017 SHALL accept a beat on any edge where s_valid=1 and s_ready=1; beats received form the frame in order, beat k to shadow[k].
REQ-018 SHALL use a fill FSM with states FILL, DROP and FULL.
- FILL: s_ready=1.
- FULL: shadow buffer holds a complete frame; s_ready=0.
- DROP: s_ready=1; accepted beats are discarded.
REQ-019 SHALL handle a normal frame: the beat at index INPUT_SIZE-1 with s_last=1 goes FILL→FULL, and the index resets to 0.
REQ-020 SHALL handle a short frame: s_last=1 at index < INPUT_SIZE-1 zero-fills the remaining shadow entries, pulses frame_err next cycle, and goes FILL→FULL.
REQ-021 SHALL handle a long frame: the beat at index INPUT_SIZE-1 with s_last=0 completes the frame and goes FILL→DROP.
- In DROP, the first accepted beat with s_last=1 pulses frame_err next cycle and goes DROP→FULL.
- Frames are not launched while in DROP.
REQ-022 SHALL track network state with a net_busy flag, set on launch.
REQ-023 SHALL clear net_busy on the first edge where output_ready=1 and the previous-cycle output_ready was 0 (rising edge), and only while net_busy=1.
REQ-024 SHALL launch on an edge where FSM=FULL and net_busy=0. In that edge:
- input_data ← shadow
- input_ready ← 1 for exactly one cycle
- net_busy ← 1
- frames_sent ← frames_sent+1
- FSM ← FILL
REQ-025 SHALL have latency: with the network idle, input_ready and the new input_data are visible the cycle after the edge that completed FULL.
REQ-026 SHALL hold input_data stable between launches.
REQ-027 SHALL allow filling while the network is busy (one frame buffered); it SHALL NOT overwrite input_data while busy.
REQ-028 SHALL handle an output_ready rise on the same edge a launch would be evaluated as follows: net_busy clears on that edge, and the launch occurs on the following edge (no bypass).
REQ-029 SHALL run a busy counter: it counts cycles with net_busy=1 and resets on launch. On reaching TIMEOUT-1, the next edge clears net_busy and pulses timeout.
REQ-030 SHALL ignore output_ready rises while net_busy=0.
REQ-031 SHALL hold s_data/s_last don't-care when s_valid=0; the index SHALL advance only on accepted beats.

Reset
REQ-032 SHALL drive reset values as follows:
- FSM=FILL, index 0, net_busy=0
- s_ready=1 in the first cycle after reset
- input_ready=0, frame_err=0, timeout=0, frames_sent=0
- input_data all zero, shadow all zero, output_ready history=0, busy counter=0
REQ-033 SHALL abort any partial or buffered frame on reset mid-operation, with no launch and no error pulse.

Verification
REQ-034 SHALL cover a normal frame: 16 beats s_data=k*64, s_last on beat 15, network idle → one input_ready pulse on the next cycle, input_data[k]=k*64, frames_sent=1.
REQ-035 SHALL cover a short frame: 5 beats, s_last on beat 4 → frame_err pulse, input_data[5..15]=0, launch occurs.
REQ-036 SHALL cover a long frame: 20 beats, s_last on beat 19 → beats 16..19 dropped, s_ready=1 throughout, frame_err pulse after beat 19, input_data holds beats 0..15.
REQ-037 SHALL cover back-to-back frames: two frames with output_ready withheld → second frame sits in FULL with s_ready=0.
- A later output_ready rise launches the second frame two edges after the rise.
- input_data is unchanged until then.
REQ-038 SHALL cover timeout with TIMEOUT=8: no output_ready → timeout pulse 8 cycles after launch, and the buffered frame then launches.
REQ-039 SHALL cover reset at beat 7 of 16 → s_ready=1, index 0, no input_ready.
- The next full frame launches normally with frames_sent=1.
